alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Handshaked, sequential 8-bit ALU responder: accepts one operation request (two operands plus 4-bit opcode), computes it, and returns the result with carry/flag outputs over a valid/ready response channel. It serves as the ALU endpoint that the team's stimulus drivers and sequencers issue operations to. Multiply and divide are iterative (one bit per cycle); all other opcodes complete in one cycle.

## Interface
- WIDTH, 8, operand/result width; iterative ops take WIDTH cycles
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_a  in  WIDTH  operand a
- req_b  in  WIDTH  operand b
- req_sel  in  4  opcode
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_out  out  WIDTH  result (mul: low half; div: quotient)
- rsp_hi  out  WIDTH  mul: high half; div: remainder; else 0
- rsp_carry  out  1  add carry-out / sub borrow; else 0
- rsp_err  out  1  divide-by-zero or disabled opcode

## Operation
- Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 shl1, 5 shr1, 6 rol1, 7 ror1, 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor, 14 gt (out=1 if a>b unsigned), 15 eq (out=1 if a==b).
- Arithmetic unsigned. add: {carry,out}=a+b. sub: out=a-b mod 2^WIDTH, carry=(a<b).
- States: IDLE -> (accept, sel 2 or 3 with b!=0) MUL/DIV; IDLE -> (accept, other) RESP; MUL/DIV -> RESP after WIDTH iterations; RESP -> IDLE when rsp_ready.
- req_ready = (state==IDLE); accept = req_valid & req_ready; operands and opcode latched on accept.
- MUL: shift-add, multiplier LSB first. DIV: restoring, quotient MSB first.
- Div by zero: no iteration; out=all ones, hi=a, err=1, straight to RESP.
- Response outputs stable while rsp_valid & !rsp_ready.

## Timing
- Reset: state IDLE, req_ready=1 (after reset deasserts), rsp_valid=0, rsp_out=0, rsp_hi=0, rsp_carry=0, rsp_err=0, iteration counter 0.
- Accept at edge N: single-cycle op -> rsp_valid high after edge N+1... i.e. visible in cycle N+1; mul/div -> visible in cycle N+1+WIDTH (N+9 for WIDTH=8).
- Response handshake at edge M (rsp_valid & rsp_ready): rsp_valid low and req_ready high in cycle M+1; peak throughput one simple op per 2 cycles.
- req_valid while busy: ignored, no latch; requester must hold.
- Reset mid-MUL/DIV or mid-RESP: operation discarded, no response produced.

## Configuration
- ALU_SEQ_DIV_EN defined: DIV state and restoring divider compiled in, opcode 3 as above.
- Undefined: no divider logic; opcode 3 completes in one cycle with out=0, hi=0, carry=0, err=1.

## Structure
- Package alu_seq_pkg: opcode localparams (ALU_ADD..ALU_EQ), state encoding (IDLE, MUL, DIV, RESP).
- Sub-module alu_seq_muldiv: iterative engine with start, op, a, b inputs and done, lo, hi outputs; owns the counter; divider portion under ALU_SEQ_DIV_EN.

## Test plan
- add a=0x0A b=0x02 -> out=0x0C, carry=0, hi=0, err=0, rsp_valid one cycle after accept.
- add a=0xF6 b=0x0A -> out=0x00, carry=1; sub 0x02-0x0A -> out=0xF8, carry=1.
- mul 0xF6*0x0A -> out=0x9C, hi=0x09, rsp_valid exactly 9 cycles after accept; req_ready low throughout.
- div 0x0A/0x02 -> out=0x05, hi=0x00; div 0xF6/0x00 -> out=0xFF, hi=0xF6, err=1 after 1 cycle (macro undefined: out=0, err=1).
- Backpressure: rsp_ready low 5 cycles on xor 0xF0^0x3C -> out=0xCC held stable, new req_valid not accepted until cycle after handshake.
- Assert rst at cycle 4 of a mul -> all outputs reset values, no rsp_valid; next add 0x0A+0x02 returns 0x0C.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU responder: opcode values and
// the FSM state encoding used by alu_seq_unit.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_SHL  = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;
    localparam logic [3:0] ALU_NAND = 4'd12;
    localparam logic [3:0] ALU_XNOR = 4'd13;
    localparam logic [3:0] ALU_GT   = 4'd14;
    localparam logic [3:0] ALU_EQ   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply/divide engine, one bit per cycle for WIDTH cycles.
// op_i = 0: shift-add multiply (multiplier LSB first), hi:lo = a*b.
// op_i = 1: restoring divide (quotient MSB first), lo = a/b, hi = a%b.
// The divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fit;
`endif

    // Load operands on start, then perform one multiply/divide step per cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef ALU_SEQ_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_fit   = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
`endif
        if (start_i) begin
            cnt_d  = CW'(WIDTH);
            op_d   = op_i;
            opnd_d = b_i;
            lo_d   = a_i;
            hi_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (!op_q) begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end
`ifdef ALU_SEQ_DIV_EN
            else begin
                hi_d = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_fit};
            end
`endif
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= 1'b0;
            opnd_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            opnd_q <= opnd_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU responder. Single-cycle ops are computed at
// accept and registered; mul/div run in alu_seq_muldiv and are returned
// from the engine registers. Define ALU_SEQ_DIV_EN to build the divider;
// otherwise opcode 3 answers immediately with err=1.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_carry,
    output logic             rsp_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, hi_q;
    logic             carry_q, err_q, eng_sel_q;

    logic [WIDTH-1:0] res_out, res_hi;
    logic             res_carry, res_err;
    logic             eng_go, eng_op, eng_done;
    logic [WIDTH-1:0] eng_lo, eng_hi;
    logic             accept;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;

    // Decode the request: single-cycle result, or hand-off to the engine.
    always_comb begin
        res_out   = '0;
        res_hi    = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        eng_go    = 1'b0;
        eng_op    = 1'b0;
        case (req_sel)
            ALU_ADD:  {res_carry, res_out} = {1'b0, req_a} + {1'b0, req_b};
            ALU_SUB: begin
                res_out   = req_a - req_b;
                res_carry = (req_a < req_b);
            end
            ALU_MUL:  eng_go = 1'b1;
            ALU_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (req_b == '0) begin
                    res_out = '1;
                    res_hi  = req_a;
                    res_err = 1'b1;
                end else begin
                    eng_go = 1'b1;
                    eng_op = 1'b1;
                end
`else
                res_err = 1'b1;
`endif
            end
            ALU_SHL:  res_out = {req_a[WIDTH-2:0], 1'b0};
            ALU_SHR:  res_out = {1'b0, req_a[WIDTH-1:1]};
            ALU_ROL:  res_out = {req_a[WIDTH-2:0], req_a[WIDTH-1]};
            ALU_ROR:  res_out = {req_a[0], req_a[WIDTH-1:1]};
            ALU_AND:  res_out = req_a & req_b;
            ALU_OR:   res_out = req_a | req_b;
            ALU_XOR:  res_out = req_a ^ req_b;
            ALU_NOR:  res_out = ~(req_a | req_b);
            ALU_NAND: res_out = ~(req_a & req_b);
            ALU_XNOR: res_out = ~(req_a ^ req_b);
            ALU_GT:   res_out = WIDTH'(req_a > req_b);
            ALU_EQ:   res_out = WIDTH'(req_a == req_b);
            default:  ;
        endcase
    end

    // Next-state logic for the request/compute/response sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = eng_go ? (eng_op ? DIV : MUL) : RESP;
            MUL, DIV: if (eng_done) state_d = RESP;
            RESP:     if (rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register plus response registers captured at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            hi_q      <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            eng_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_q     <= res_out;
                hi_q      <= res_hi;
                carry_q   <= res_carry;
                err_q     <= res_err;
                eng_sel_q <= eng_go;
            end
        end
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept & eng_go),
        .op_i    (eng_op),
        .a_i     (req_a),
        .b_i     (req_b),
        .done_o  (eng_done),
        .lo_o    (eng_lo),
        .hi_o    (eng_hi)
    );

    // Engine results are held in its registers once the count expires.
    assign rsp_valid = (state_q == RESP);
    assign rsp_out   = eng_sel_q ? eng_lo : out_q;
    assign rsp_hi    = eng_sel_q ? eng_hi : hi_q;
    assign rsp_carry = carry_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, random ops
// against an arithmetic reference model, backpressure and mid-op reset.
module tb_alu_seq_unit;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [3:0] req_sel = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_out, rsp_hi;
    logic       rsp_carry, rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_hi    (rsp_hi),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a, b;
        logic [7:0] out, hi;
        logic       carry, err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    task automatic model(input int sel, input int a, input int b,
                         output int out, output int hi, output int carry,
                         output int err, output int lat);
        out = 0; hi = 0; carry = 0; err = 0; lat = 1;
        case (sel)
            0:  begin out = (a + b) % 256; carry = ((a + b) > 255) ? 1 : 0; end
            1:  begin out = (a - b + 256) % 256; carry = (a < b) ? 1 : 0; end
            2:  begin out = (a * b) % 256; hi = (a * b) / 256; lat = 9; end
            3:  begin
                if (!DIV_EN) err = 1;
                else if (b == 0) begin out = 255; hi = a; err = 1; end
                else begin out = a / b; hi = a % b; lat = 9; end
            end
            4:  out = (a * 2) % 256;
            5:  out = a / 2;
            6:  out = (a * 2) % 256 + a / 128;
            7:  out = a / 2 + (a % 2) * 128;
            8:  out = a & b;
            9:  out = a | b;
            10: out = a ^ b;
            11: out = 255 - (a | b);
            12: out = 255 - (a & b);
            13: out = 255 - (a ^ b);
            14: out = (a > b) ? 1 : 0;
            default: out = (a == b) ? 1 : 0;
        endcase
    endtask

    function automatic int exp_lat(input logic [3:0] sel, input logic [7:0] b);
        if (sel == 4'd2) return 9;
        if (sel == 4'd3 && DIV_EN && b != 8'd0) return 9;
        return 1;
    endfunction

    task automatic add_vec(input logic [3:0] sel, input logic [7:0] a, b, out, hi,
                           input logic carry, err);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.out = out; v.hi = hi; v.carry = carry; v.err = err;
        vecs.push_back(v);
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic [3:0] sel, input logic [7:0] a, b);
        int guard = 0;
        @(negedge clk);
        req_sel = sel; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait for the response, check it, hold it for 'stall' cycles, then take it.
    task automatic collect(input string name, input int stall,
                           input logic [7:0] e_out, e_hi, input logic e_carry, e_err,
                           input int e_lat);
        int         lat = 0;
        logic       busy_ok = 1'b1;
        logic       stable = 1'b1;
        logic [7:0] o, h;
        logic       c, e;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid && req_ready) busy_ok = 1'b0;
        end while (!rsp_valid && lat < 40);
        check({name, "_latency"}, lat, e_lat);
        check({name, "_ready_low_while_busy"}, busy_ok, 1'b1);
        check({name, "_out"}, rsp_out, e_out);
        check({name, "_hi"}, rsp_hi, e_hi);
        check({name, "_carry"}, rsp_carry, e_carry);
        check({name, "_err"}, rsp_err, e_err);
        o = rsp_out; h = rsp_hi; c = rsp_carry; e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_out !== o || rsp_hi !== h ||
                rsp_carry !== c || rsp_err !== e) stable = 1'b0;
        end
        if (stall > 0) check({name, "_stable"}, stable, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, rsp_valid, 1'b0);
        check({name, "_ready_back"}, req_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   m_out, m_hi, m_carry, m_err, m_lat;
        logic seen;
        logic bp_stable, bp_ready_low;
        int   lat;

        // Directed vectors.
        add_vec(4'd0,  8'h0A, 8'h02, 8'h0C, 8'h00, 1'b0, 1'b0);
        add_vec(4'd0,  8'hF6, 8'h0A, 8'h00, 8'h00, 1'b1, 1'b0);
        add_vec(4'd1,  8'h02, 8'h0A, 8'hF8, 8'h00, 1'b1, 1'b0);
        add_vec(4'd1,  8'h0A, 8'h02, 8'h08, 8'h00, 1'b0, 1'b0);
        add_vec(4'd2,  8'hF6, 8'h0A, 8'h9C, 8'h09, 1'b0, 1'b0);
        add_vec(4'd2,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
`ifdef ALU_SEQ_DIV_EN
        add_vec(4'd3,  8'h0A, 8'h02, 8'h05, 8'h00, 1'b0, 1'b0);
        add_vec(4'd3,  8'hF6, 8'h00, 8'hFF, 8'hF6, 1'b0, 1'b1);
        add_vec(4'd3,  8'hF7, 8'h0A, 8'h18, 8'h07, 1'b0, 1'b0);
`else
        add_vec(4'd3,  8'h0A, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1);
        add_vec(4'd3,  8'hF6, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
`endif
        add_vec(4'd4,  8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0);
        add_vec(4'd5,  8'h81, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0);
        add_vec(4'd6,  8'h81, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0);
        add_vec(4'd7,  8'h81, 8'h00, 8'hC0, 8'h00, 1'b0, 1'b0);
        add_vec(4'd8,  8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0);
        add_vec(4'd9,  8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0);
        add_vec(4'd10, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0);
        add_vec(4'd11, 8'hF0, 8'h3C, 8'h03, 8'h00, 1'b0, 1'b0);
        add_vec(4'd12, 8'hF0, 8'h3C, 8'hCF, 8'h00, 1'b0, 1'b0);
        add_vec(4'd13, 8'hF0, 8'h3C, 8'h33, 8'h00, 1'b0, 1'b0);
        add_vec(4'd14, 8'h05, 8'h03, 8'h01, 8'h00, 1'b0, 1'b0);
        add_vec(4'd14, 8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
        add_vec(4'd15, 8'h7E, 8'h7E, 8'h01, 8'h00, 1'b0, 1'b0);
        add_vec(4'd15, 8'h7E, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_out", rsp_out, 8'h00);
        check("reset_rsp_hi", rsp_hi, 8'h00);
        check("reset_rsp_carry", rsp_carry, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].sel, vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d_sel%0d", i, vecs[i].sel), i % 3,
                    vecs[i].out, vecs[i].hi, vecs[i].carry, vecs[i].err,
                    exp_lat(vecs[i].sel, vecs[i].b));
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] s;
            logic [7:0] a, b;
            s = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(int'(s), int'(a), int'(b), m_out, m_hi, m_carry, m_err, m_lat);
            issue(s, a, b);
            collect($sformatf("rand%0d_sel%0d", i, s), int'($urandom_range(0, 2)),
                    8'(m_out), 8'(m_hi), 1'(m_carry), 1'(m_err), m_lat);
        end

        // Backpressure: xor response held 5 cycles while a new request waits.
        issue(4'd10, 8'hF0, 8'h3C);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check("bp_latency", lat, 1);
        check("bp_out", rsp_out, 8'hCC);
        req_sel = 4'd0; req_a = 8'h0A; req_b = 8'h02; req_valid = 1'b1;
        bp_stable = 1'b1;
        bp_ready_low = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid || rsp_out !== 8'hCC || rsp_carry !== 1'b0 || rsp_err !== 1'b0)
                bp_stable = 1'b0;
            if (req_ready) bp_ready_low = 1'b0;
        end
        check("bp_held_stable", bp_stable, 1'b1);
        check("bp_not_accepted", bp_ready_low, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_drop", rsp_valid, 1'b0);
        check("bp_ready_after_hs", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", rsp_valid, 1'b1);
        check("bp_next_out", rsp_out, 8'h0C);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset during a multiply: operation discarded.
        issue(4'd2, 8'hF6, 8'h0A);
        repeat (3) @(negedge clk);
        check("rst_mul_busy", req_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", rsp_valid, 1'b0);
        check("rst_mid_out", rsp_out, 8'h00);
        check("rst_mid_hi", rsp_hi, 8'h00);
        check("rst_mid_carry", rsp_carry, 1'b0);
        check("rst_mid_err", rsp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rst_no_response", seen, 1'b0);
        check("rst_ready_after", req_ready, 1'b1);
        issue(4'd0, 8'h0A, 8'h02);
        collect("post_rst_add", 0, 8'h0C, 8'h00, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
